// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encoding, requester indices and slot state type used by
// the ALU, the decoder and the ALU arbiter.
package alu_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_AND  = 4'b0010;
  localparam alu_op_t ALU_OR   = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_SLL  = 4'b0101;
  localparam alu_op_t ALU_SRL  = 4'b0110;
  localparam alu_op_t ALU_SRA  = 4'b0111;
  localparam alu_op_t ALU_SLT  = 4'b1000;
  localparam alu_op_t ALU_SLTU = 4'b1001;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HOLD  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU; opcodes outside ADD..SLTU produce zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU, with a single registered result
// slot that is handed back on the winning requester's response port.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_op,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output slot_state_e     dbg_state
);

  // Handshake: a transfer happens on a port in a cycle where valid and ready
  // are both high at the rising edge; valid never waits for ready, and a
  // requester holds its operands while valid is high and ready is low.

  slot_state_e     state_q, state_d;
  logic            owner_q, owner_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            prio_q, prio_d;

  logic            grant_any;
  logic            grant_idx;
  logic            owner_fire;
  logic            accept;

  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [3:0]      alu_op;
  logic            alu_zero;

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_idx = REQ0;
    if (req0_valid && req1_valid) begin
      grant_idx = (FIXED_PRIO != 0) ? REQ0 : prio_q;
    end else if (req1_valid) begin
      grant_idx = REQ1;
    end
  end

  // A draining slot can take a new op in the same cycle for full throughput.
  assign owner_fire = (state_q == SLOT_HOLD) &&
                      ((owner_q == REQ0) ? rsp0_ready : rsp1_ready);
  assign accept     = !rst && grant_any &&
                      ((state_q == SLOT_EMPTY) || owner_fire);

  assign req0_ready = accept && (grant_idx == REQ0);
  assign req1_ready = accept && (grant_idx == REQ1);

  assign alu_a  = (grant_idx == REQ1) ? req1_a  : req0_a;
  assign alu_b  = (grant_idx == REQ1) ? req1_b  : req0_b;
  assign alu_op = (grant_idx == REQ1) ? req1_op : req0_op;

  alu_arbiter_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
    prio_d   = prio_q;
    if (accept) begin
      state_d  = SLOT_HOLD;
      owner_d  = grant_idx;
      result_d = alu_result;
      zero_d   = alu_zero;
      if (FIXED_PRIO == 0) begin
        prio_d = !grant_idx;
      end
    end else if (owner_fire) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      owner_q  <= REQ0;
      result_q <= '0;
      zero_q   <= 1'b0;
      prio_q   <= REQ0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      prio_q   <= prio_d;
    end
  end

  assign rsp0_valid  = (state_q == SLOT_HOLD) && (owner_q == REQ0);
  assign rsp1_valid  = (state_q == SLOT_HOLD) && (owner_q == REQ1);
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign dbg_state   = state_q;

endmodule
